alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 91 +++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - opcode constants and result-register state encoding
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SLL  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd13;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU shared by both requesters
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << b[4:0];
            OP_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'b0, a < b};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            // unknown opcodes still complete, with a zero result
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter feeding one ALU into a single result register
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_zero
);

    state_t      state, state_next;
    logic        last_grant;
    logic        grant;
    logic        can_accept;
    logic        handshake;
    logic [31:0] sel_a, sel_b, alu_result;
    logic [3:0]  sel_op;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;
        else if (FAIR)
            grant = ~last_grant;
        else
            grant = 1'b0;
    end

    // readys are forced low during reset so nothing is consumed while the register clears
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign req0_ready = rst_n && can_accept && !grant;
    assign req1_ready = rst_n && can_accept && grant;
    assign handshake  = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;
    assign sel_op = grant ? req1_op : req0_op;

    alu u_alu (
        .a      (sel_a),
        .b      (sel_b),
        .op     (sel_op),
        .result (alu_result)
    );

    always_comb begin
        state_next = state;
        if (handshake)
            state_next = FULL;
        else if (can_accept)
            state_next = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_next;
            if (handshake) begin
                last_grant <= grant;
                rsp_id     <= grant;
                rsp_data   <= alu_result;
                rsp_zero   <= (alu_result == 32'd0);
            end
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for fair and fixed-priority alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;

    logic        f_r0, f_r1, f_rv, f_id, f_zero;
    logic [31:0] f_data;
    logic        x_r0, x_r1, x_rv, x_id, x_zero;
    logic [31:0] x_data;

    int checks = 0;
    int failures = 0;

    logic        m_valid[2];
    logic        m_id[2];
    logic [31:0] m_data[2];
    logic        m_zero[2];
    logic        m_last[2];

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1'b1)) dut_fair (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(f_r0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(f_r1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .rsp_valid(f_rv), .rsp_ready(rsp_ready), .rsp_id(f_id), .rsp_data(f_data), .rsp_zero(f_zero)
    );

    alu_arbiter #(.FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(x_r0), .req0_a(a0), .req0_b(b0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(x_r1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
        .rsp_valid(x_rv), .rsp_ready(rsp_ready), .rsp_id(x_id), .rsp_data(x_data), .rsp_zero(x_zero)
    );

    // Reference ALU built from arithmetic definitions rather than shift/compare operators
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        longint unsigned p2;
        logic [31:0] mask;
        p2   = 64'd1 << b[4:0];
        mask = 32'(64'hFFFF_FFFF / p2);
        case (op)
            4'd0:    return a + b;
            4'd8:    return a + (~b) + 32'd1;
            4'd1:    return 32'((64'(a) * p2) % 64'h1_0000_0000);
            4'd5:    return 32'(64'(a) / p2);
            4'd13:   return 32'(64'(a) / p2) | (a[31] ? ~mask : 32'd0);
            4'd2:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s_%s observed=%h expected=%h", (k == 0) ? "fair" : "fixed", tag, obs, exp);
        end
    endtask

    // One clock: check readys before the edge, advance the model, check the result register after it
    task automatic do_cycle();
        logic        g, can, er0, er1, hs, rst_s;
        logic [31:0] res;
        logic        n_valid[2];
        logic        n_id[2];
        logic [31:0] n_data[2];
        logic        n_zero[2];
        logic        n_last[2];
        #1;
        rst_s = rst_n;
        for (int k = 0; k < 2; k++) begin
            can = !m_valid[k] || rsp_ready;
            if (v0 && !v1)      g = 1'b0;
            else if (v1 && !v0) g = 1'b1;
            else if (k == 0)    g = !m_last[k];
            else                g = 1'b0;
            er0 = rst_n && can && !g;
            er1 = rst_n && can && g;
            if (v0 || v1 || !can || !rst_n) begin
                chk(k, "req0_ready", (k == 0) ? f_r0 : x_r0, er0);
                chk(k, "req1_ready", (k == 0) ? f_r1 : x_r1, er1);
            end
            hs  = g ? (v1 && er1) : (v0 && er0);
            res = g ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
            n_valid[k] = m_valid[k];
            n_id[k]    = m_id[k];
            n_data[k]  = m_data[k];
            n_zero[k]  = m_zero[k];
            n_last[k]  = m_last[k];
            if (!rst_n) begin
                n_valid[k] = 1'b0; n_id[k] = 1'b0; n_data[k] = '0; n_zero[k] = 1'b0; n_last[k] = 1'b1;
            end else if (hs) begin
                n_valid[k] = 1'b1; n_id[k] = g; n_data[k] = res; n_zero[k] = (res == 32'd0); n_last[k] = g;
            end else if (can) begin
                n_valid[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = n_valid[k];
            m_id[k]    = n_id[k];
            m_data[k]  = n_data[k];
            m_zero[k]  = n_zero[k];
            m_last[k]  = n_last[k];
            chk(k, "rsp_valid", (k == 0) ? f_rv : x_rv, m_valid[k]);
            if (m_valid[k] || !rst_s) begin
                chk(k, "rsp_id",   (k == 0) ? f_id : x_id, m_id[k]);
                chk(k, "rsp_data", (k == 0) ? f_data : x_data, m_data[k]);
                chk(k, "rsp_zero", (k == 0) ? f_zero : x_zero, m_zero[k]);
            end
        end
    endtask

    initial begin
        logic [31:0] hold;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_id[k] = 1'b0; m_data[k] = '0; m_zero[k] = 1'b0; m_last[k] = 1'b1;
        end
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        do_cycle();
        do_cycle();
        chk(0, "reset_valid", f_rv, 1'b0);
        chk(0, "reset_data", f_data, 32'd0);
        rst_n = 1'b1;

        v0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 4'd8;
        do_cycle();
        chk(0, "sub_valid", f_rv, 1'b1);
        chk(0, "sub_id", f_id, 1'b0);
        chk(0, "sub_data", f_data, 32'd2);
        chk(0, "sub_zero", f_zero, 1'b0);
        v0 = 1'b0;
        do_cycle();

        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        v0 = 1'b1; v1 = 1'b1; a0 = 32'h1234; b0 = 32'h55; op0 = 4'd9;
        a1 = 32'hFFFF_FFFF; b1 = 32'd1; op1 = 4'd0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk(0, "alt_id", f_id, 32'(i % 2));
            chk(0, "alt_zero", f_zero, 1'b1);
            chk(1, "fixed_id", x_id, 1'b0);
            chk(1, "fixed_op9_data", x_data, 32'd0);
            chk(1, "fixed_op9_zero", x_zero, 1'b1);
        end

        op0 = 4'd0;
        rsp_ready = 1'b0;
        hold = f_data;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk(0, "stall_hold", f_data, hold);
        end
        rsp_ready = 1'b1;
        do_cycle();
        chk(0, "stall_release_valid", f_rv, 1'b1);

        v0 = 1'b0; v1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'd4; op1 = 4'd13;
        do_cycle();
        chk(0, "sra", f_data, 32'hF800_0000);
        op1 = 4'd5;
        do_cycle();
        chk(0, "srl", f_data, 32'h0800_0000);
        b1 = 32'd1; op1 = 4'd2;
        do_cycle();
        chk(0, "slt", f_data, 32'd1);
        op1 = 4'd3;
        do_cycle();
        chk(0, "sltu", f_data, 32'd0);

        rsp_ready = 1'b0;
        rst_n = 1'b0;
        do_cycle();
        chk(0, "rst_full_valid", f_rv, 1'b0);
        rst_n = 1'b1; rsp_ready = 1'b1;
        v0 = 1'b1; v1 = 1'b1; op0 = 4'd4; op1 = 4'd6;
        do_cycle();
        chk(0, "post_reset_grant", f_id, 1'b0);
        chk(1, "post_reset_grant", x_id, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 31) != 0);
            v0        = 1'($urandom_range(0, 1));
            v1        = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            a0  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b0  = ($urandom_range(0, 7) == 0) ? a0 : $urandom;
            a1  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b1  = $urandom;
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 15));
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
